// File: rtl/bsg_link_iddr_align_ctrl.sv
// bsg_link_iddr_align_ctrl
// Word-alignment controller for the IDDR receive path. It finds which clock
// edge starts each 2*width_p word using a repeating training word {~P, P},
// confirms that choice over lock_count_p cycles, then streams
// phase-corrected words.
//
// Ports:
//   clk_i       in   clock shared with the IDDR PHY
//   reset_n_i   in   synchronous active-low reset
//   train_en_i  in   1 while the far end transmits the training pattern
//   data_i      in   PHY word: low half = posedge sample, high half = negedge sample
//   data_o      out  phase-aligned word (1 cycle latency)
//   valid_o     out  data_o carries payload
//   locked_o    out  alignment found and held
//   phase_o     out  0 = word starts on posedge, 1 = word starts on negedge
//   timeout_o   out  one-cycle pulse when the search window expires
module bsg_link_iddr_align_ctrl #(
  parameter int unsigned width_p      = 32,
  parameter logic [width_p-1:0] pattern_p = 32'hA5C3_5A3C,
  parameter int unsigned lock_count_p = 8,
  parameter int unsigned timeout_p    = 1024
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 train_en_i,
  input  logic [2*width_p-1:0] data_i,
  output logic [2*width_p-1:0] data_o,
  output logic                 valid_o,
  output logic                 locked_o,
  output logic                 phase_o,
  output logic                 timeout_o
);

  localparam int unsigned DW = 2 * width_p;
  localparam int unsigned CW = $clog2(lock_count_p + 1);
  localparam int unsigned TW = $clog2(timeout_p);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEARCH  = 3'd1,
    CONFIRM = 3'd2,
    LOCKED  = 3'd3,
    RUN     = 3'd4
  } state_e;

  state_e             state_q;
  logic [DW-1:0]      data_q;
  logic               valid_q;
  logic               locked_q;
  logic               phase_q;
  logic               timeout_q;
  logic [width_p-1:0] prev_hi_q;
  logic [CW-1:0]      match_cnt_q;
  logic [TW-1:0]      timer_q;

  logic [DW-1:0] aligned1_c;
  logic          m0_c;
  logic          m1_c;
  logic          match_cur_c;
  logic          lock_c;
  logic          timer_last_c;

  // Phase-1 word: previous negedge half followed by current posedge half
  assign aligned1_c   = {data_i[width_p-1:0], prev_hi_q};
  assign m0_c         = (data_i == {~pattern_p, pattern_p});
  assign m1_c         = (data_i == {pattern_p, ~pattern_p});
  assign match_cur_c  = phase_q ? m1_c : m0_c;
  assign timer_last_c = (timer_q == TW'(timeout_p - 1));

  // Lock is reached on the match that makes the count equal lock_count_p;
  // with lock_count_p == 1 that is the very first match seen in SEARCH.
  assign lock_c = (state_q == SEARCH)
                  ? ((m0_c || m1_c) && (lock_count_p == 1))
                  : (match_cur_c && ((match_cnt_q + CW'(1)) == CW'(lock_count_p)));

  // Alignment FSM with registered outputs
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      data_q      <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      phase_q     <= 1'b0;
      timeout_q   <= 1'b0;
      prev_hi_q   <= '0;
      match_cnt_q <= '0;
      timer_q     <= '0;
    end else begin
      prev_hi_q <= data_i[DW-1:width_p];
      data_q    <= phase_q ? aligned1_c : data_i;
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (train_en_i) begin
            state_q     <= SEARCH;
            timer_q     <= '0;
            match_cnt_q <= '0;
          end
        end
        SEARCH, CONFIRM: begin
          if (!train_en_i) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            match_cnt_q <= '0;
          end else if (lock_c) begin
            // Lock beats a same-cycle timeout; timer is frozen from here on
            state_q     <= LOCKED;
            locked_q    <= 1'b1;
            match_cnt_q <= CW'(lock_count_p);
            if (state_q == SEARCH) phase_q <= ~m0_c;
          end else if (timer_last_c) begin
            timeout_q   <= 1'b1;
            timer_q     <= '0;
            match_cnt_q <= '0;
            state_q     <= SEARCH;
          end else begin
            timer_q <= timer_q + TW'(1);
            if (state_q == SEARCH) begin
              // Phase 0 wins a tie
              if (m0_c || m1_c) begin
                state_q     <= CONFIRM;
                phase_q     <= ~m0_c;
                match_cnt_q <= CW'(1);
              end
            end else if (match_cur_c) begin
              match_cnt_q <= match_cnt_q + CW'(1);
            end else begin
              state_q     <= SEARCH;
              match_cnt_q <= '0;
            end
          end
        end
        LOCKED: begin
          if (!train_en_i) begin
            state_q <= RUN;
            valid_q <= 1'b1;
          end else if (!match_cur_c) begin
            state_q     <= SEARCH;
            locked_q    <= 1'b0;
            timer_q     <= '0;
            match_cnt_q <= '0;
          end
        end
        RUN: begin
          if (train_en_i) begin
            state_q     <= SEARCH;
            locked_q    <= 1'b0;
            valid_q     <= 1'b0;
            timer_q     <= '0;
            match_cnt_q <= '0;
          end
        end
        default: begin
          state_q  <= IDLE;
          locked_q <= 1'b0;
          valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign locked_o  = locked_q;
  assign phase_o   = phase_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_bsg_link_iddr_align_ctrl.sv
// Bench for bsg_link_iddr_align_ctrl: a behavioural reference model pushes the
// expected registered outputs into a scoreboard queue as each input cycle is
// driven; they are popped and compared after the clock edge. Directed checks
// cover the lock latency, phases, payload alignment, timeout and reset cases.
module tb_bsg_link_iddr_align_ctrl;

  localparam int unsigned W  = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned LC = 8;
  localparam int unsigned TO = 16;
  localparam logic [W-1:0]  P  = 32'hA5C3_5A3C;
  localparam logic [DW-1:0] W0 = {~P, P};
  localparam logic [DW-1:0] W1 = {P, ~P};

  localparam int S_IDLE = 0, S_SEARCH = 1, S_CONFIRM = 2, S_LOCKED = 3, S_RUN = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          train_en;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_o;
  logic          valid_o, locked_o, phase_o, timeout_o;

  always #5 clk = ~clk;

  bsg_link_iddr_align_ctrl #(
    .width_p(W), .pattern_p(P), .lock_count_p(LC), .timeout_p(TO)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .train_en_i(train_en), .data_i(data_in),
    .data_o(data_o), .valid_o(valid_o), .locked_o(locked_o),
    .phase_o(phase_o), .timeout_o(timeout_o)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          valid;
    logic          locked;
    logic          phase;
    logic          timeout;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  int            m_st = S_IDLE;
  int            m_tm = 0;
  int            m_cn = 0;
  logic          m_ph = 1'b0;
  logic [W-1:0]  m_prev = '0;
  logic [DW-1:0] m_data = '0;
  logic          m_to = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst_n, input logic train, input logic [DW-1:0] d);
    logic m0, m1, mc, lock;
    m0 = (d == W0);
    m1 = (d == W1);
    mc = m_ph ? m1 : m0;
    m_to = 1'b0;
    if (!rst_n) begin
      m_st = S_IDLE; m_tm = 0; m_cn = 0; m_ph = 1'b0; m_prev = '0; m_data = '0;
      return;
    end
    m_data = m_ph ? {d[W-1:0], m_prev} : d;
    m_prev = d[DW-1:W];
    case (m_st)
      S_IDLE: if (train) begin m_st = S_SEARCH; m_tm = 0; m_cn = 0; end
      S_SEARCH, S_CONFIRM: begin
        if (m_st == S_SEARCH) lock = (m0 || m1) && (LC == 1);
        else                  lock = mc && (m_cn + 1 == int'(LC));
        if (!train) begin
          m_st = S_IDLE; m_tm = 0; m_cn = 0;
        end else if (lock) begin
          if (m_st == S_SEARCH) m_ph = !m0;
          m_st = S_LOCKED; m_cn = LC;
        end else if (m_tm == int'(TO) - 1) begin
          m_to = 1'b1; m_tm = 0; m_cn = 0; m_st = S_SEARCH;
        end else begin
          m_tm++;
          if (m_st == S_SEARCH) begin
            if (m0)      begin m_st = S_CONFIRM; m_ph = 1'b0; m_cn = 1; end
            else if (m1) begin m_st = S_CONFIRM; m_ph = 1'b1; m_cn = 1; end
          end else if (mc) m_cn++;
          else begin m_st = S_SEARCH; m_cn = 0; end
        end
      end
      S_LOCKED: begin
        if (!train) m_st = S_RUN;
        else if (!mc) begin m_st = S_SEARCH; m_tm = 0; m_cn = 0; end
      end
      S_RUN: if (train) begin m_st = S_SEARCH; m_tm = 0; m_cn = 0; end
      default: m_st = S_IDLE;
    endcase
  endtask

  // One clock: drive on negedge, push model expectation, compare after posedge
  task automatic cycle(input logic rst_n, input logic train, input logic [DW-1:0] d);
    exp_t e;
    @(negedge clk);
    reset_n  = rst_n;
    train_en = train;
    data_in  = d;
    model_step(rst_n, train, d);
    e.data    = m_data;
    e.valid   = (m_st == S_RUN);
    e.locked  = (m_st == S_RUN) || (m_st == S_LOCKED);
    e.phase   = m_ph;
    e.timeout = m_to;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("sb_data", data_o, e.data);
    check("sb_valid", 64'(valid_o), 64'(e.valid));
    check("sb_locked", 64'(locked_o), 64'(e.locked));
    check("sb_phase", 64'(phase_o), 64'(e.phase));
    check("sb_timeout", 64'(timeout_o), 64'(e.timeout));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first;
    int pulses;
    int p_first, p_second;
    logic to_seen;
    logic tr;
    logic md;

    reset_n = 1'b0; train_en = 1'b0; data_in = '0;
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    check("reset_data", data_o, 64'h0);
    check("reset_locked", 64'(locked_o), 64'h0);

    // Phase-0 lock: 1 IDLE->SEARCH edge plus 8 matching cycles
    first = -1; to_seen = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, 1'b1, W0);
      if (locked_o && first < 0) first = i;
      to_seen |= timeout_o;
    end
    check("lock0_cycle", 64'(first), 64'd9);
    check("lock0_phase", 64'(phase_o), 64'd0);
    check("lock0_no_timeout", 64'(to_seen), 64'd0);
    cycle(1'b1, 1'b0, 64'h1111_2222);
    check("run0_valid", 64'(valid_o), 64'd1);
    check("run0_data", data_o, 64'h1111_2222);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, {$urandom, $urandom});

    // Retrain from RUN into phase 1
    cycle(1'b1, 1'b1, W1);
    check("retrain_locked", 64'(locked_o), 64'd0);
    check("retrain_valid", 64'(valid_o), 64'd0);
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, 1'b1, W1);
      if (locked_o && first < 0) first = i;
    end
    check("lock1_cycle", 64'(first), 64'd8);
    check("lock1_phase", 64'(phase_o), 64'd1);

    // Phase-1 payload: low half from cycle t-1 high, high half from cycle t low
    cycle(1'b1, 1'b0, {32'hAAAA_0001, 32'h1234_5678});
    cycle(1'b1, 1'b0, {32'h9ABC_DEF0, 32'hBBBB_0002});
    check("run1_data", data_o, 64'hBBBB_0002_AAAA_0001);
    check("run1_valid", 64'(valid_o), 64'd1);

    // Broken confirm: 5 matches, a corrupted word, then 8 fresh matches
    cycle(1'b1, 1'b1, W0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, W0);
    cycle(1'b1, 1'b1, W0 ^ 64'h1);
    check("broken_unlocked", 64'(locked_o), 64'd0);
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b1, W0);
      if (i == 7) check("broken_pre_lock", 64'(locked_o), 64'd0);
    end
    check("broken_lock", 64'(locked_o), 64'd1);
    check("broken_phase", 64'(phase_o), 64'd0);

    // Reset mid-CONFIRM with training held
    cycle(1'b1, 1'b0, 64'h0);
    cycle(1'b1, 1'b1, W1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, W1);
    cycle(1'b0, 1'b1, W1);
    check("rst_confirm_data", data_o, 64'h0);
    check("rst_confirm_phase", 64'(phase_o), 64'd0);
    check("rst_confirm_locked", 64'(locked_o), 64'd0);

    // Relock then reset mid-RUN
    cycle(1'b1, 1'b1, W1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, W1);
    check("relock_after_rst", 64'(locked_o), 64'd1);
    cycle(1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001);
    cycle(1'b1, 1'b0, 64'hCAFE_F00D_0000_0002);
    cycle(1'b0, 1'b1, W1);
    check("rst_run_valid", 64'(valid_o), 64'd0);
    check("rst_run_locked", 64'(locked_o), 64'd0);
    check("rst_run_data", data_o, 64'h0);

    // Timeout: pulses 16 and 32 cycles after entering SEARCH
    pulses = 0; p_first = -1; p_second = -1;
    cycle(1'b1, 1'b1, 64'h0);
    for (int i = 1; i <= 33; i++) begin
      cycle(1'b1, 1'b1, 64'h0);
      if (timeout_o) begin
        pulses++;
        if (p_first < 0) p_first = i;
        else if (p_second < 0) p_second = i;
      end
    end
    check("timeout_pulses", 64'(pulses), 64'd2);
    check("timeout_first", 64'(p_first), 64'd16);
    check("timeout_second", 64'(p_second), 64'd32);
    cycle(1'b1, 1'b0, 64'h0);

    // Randomised mix of training, payload, corruption and resets
    tr = 1'b0; md = 1'b0;
    for (int i = 0; i < 600; i++) begin
      int sel;
      logic [DW-1:0] d;
      if ($urandom_range(0, 29) == 0) begin
        tr = ~tr;
        md = 1'($urandom_range(0, 1));
      end
      sel = $urandom_range(0, 19);
      if (!tr || sel == 0) d = {$urandom, $urandom};
      else if (sel == 1)   d = md ? W0 : W1;
      else                 d = md ? W1 : W0;
      cycle(($urandom_range(0, 149) != 0), tr, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bsg_link_iddr_align_ctrl.md
Name: bsg_link_iddr_align_ctrl

Overview:
- Receive-side word-alignment controller that sits directly after the IDDR PHY on the link RX path.
- Consumes the PHY's 2*width_p registered output, whose low half is the posedge sample and high half the negedge sample.
- During link training it searches a repeating training word to find which edge starts each word, then confirms the choice over several cycles.
- Once trained, it streams phase-corrected 2*width_p words with a valid flag to the link downstream.

Parameters:
- width_p, 32: PHY pin width; data path width is 2*width_p.
- pattern_p, 32'hA5C3_5A3C: width_p-bit training half-word P. The transmitted training word is {~P, P}, with P sent first.
- lock_count_p, 8: consecutive matching cycles required to declare lock (>=1).
- timeout_p, 1024: maximum cycles spent in SEARCH+CONFIRM before timeout (>=2).

Ports:
- clk_i  in  1  same clock as the PHY's clk_i.
- reset_n_i  in  1  synchronous, active-low reset.
- train_en_i  in  1  1 = link in training, pattern is being sent.
- data_i  in  2*width_p  PHY data_r_o.
- data_o  out  2*width_p  phase-aligned word.
- valid_o  out  1  data_o carries payload.
- locked_o  out  1  alignment found and held.
- phase_o  out  1  chosen phase: 0 = word starts on posedge, 1 = word starts on negedge.
- timeout_o  out  1  single-cycle pulse when the search window expires.

Behaviour:
- All state updates on posedge clk_i. reset_n_i=0 at any clock forces the following, overriding every other input, including mid-training and in RUN:
  - state=IDLE;
  - data_o=0, valid_o=0, locked_o=0, phase_o=0, timeout_o=0;
  - prev_hi_r=0, match_cnt=0, timer=0.
- prev_hi_r <= data_i[2w-1:w] every cycle.
- Aligned word:
  - A0 = data_i.
  - A1 = {data_i[w-1:0], prev_hi_r}.
- Match definitions:
  - M0: data_i == {~P, P}.
  - M1: data_i == {P, ~P}.
- data_o <= (phase_o ? A1 : A0) every cycle, regardless of state. Latency is 1 cycle.
- valid_o <= (next state == RUN). Therefore valid_o and data_o are coincident.
- States: IDLE, SEARCH, CONFIRM, LOCKED, RUN.
- IDLE: locked_o=0.
  - train_en_i=1 -> SEARCH, with timer=0 and match_cnt=0.
- SEARCH: timer increments each cycle.
  - M0 -> CONFIRM, phase_o<=0, match_cnt<=1.
  - else M1 -> CONFIRM, phase_o<=1, match_cnt<=1.
  - If M0 and M1 are both true (only possible when P == ~P, which is impossible), phase 0 wins.
- CONFIRM: timer increments each cycle.
  - Match for the current phase -> match_cnt++. When the incremented value equals lock_count_p -> LOCKED.
  - Mismatch -> SEARCH with match_cnt=0. phase_o holds and timer continues.
  - lock_count_p=1: SEARCH goes to LOCKED directly on the first match, skipping CONFIRM.
- Timeout: in SEARCH or CONFIRM, when timer reaches timeout_p-1 and lock is not reached that cycle:
  - timeout_o=1 for one cycle;
  - timer=0, match_cnt=0, state=SEARCH.
  - Lock in the same cycle wins: no timeout pulse.
- LOCKED: locked_o=1; timer and match_cnt frozen.
  - Mismatch while train_en_i=1 -> SEARCH, locked_o=0.
  - train_en_i=0 -> RUN.
- RUN: locked_o=1, valid_o=1, no pattern checking.
  - train_en_i=1 -> SEARCH (retrain), with locked_o=0, valid_o=0 from the next cycle, and timer=0.
- train_en_i=0 while in SEARCH or CONFIRM -> IDLE, counters cleared, phase_o holds.
- locked_o and phase_o are registered. phase_o changes only on SEARCH->CONFIRM/LOCKED transitions.
- Counter widths: match_cnt is $clog2(lock_count_p+1) bits; timer is $clog2(timeout_p) bits. Neither counter may wrap silently.

Test Plan:
- Phase-0 lock: reset, train_en_i=1, drive data_i={~P,P}=64'h5A3CA5C3_A5C35A3C for 10 cycles -> locked_o=1 after exactly 1+8 match cycles, phase_o=0, no timeout_o. Drop train_en_i and drive 64'h1111_2222 -> valid_o=1 next cycle with data_o=64'h1111_2222.
- Phase-1 lock: drive data_i={P,~P} -> phase_o=1, locked_o after 8 cycles. Run payload halves lo=0xAAAA0001 on cycle t-1 hi and hi=0xBBBB0002 on cycle t lo -> data_o=64'hBBBB0002_AAAA0001 at t+1.
- Broken confirm: 5 matching cycles, 1 corrupted word, then good words -> returns to SEARCH, lock asserted only after 8 further consecutive matches.
- Timeout: timeout_p=16, data_i=0 with train_en_i=1 -> timeout_o pulses at cycle 16 and 32, locked_o stays 0, valid_o stays 0.
- Retrain from RUN: in RUN raise train_en_i -> locked_o and valid_o go to 0 the next cycle, SEARCH re-entered. Supply pattern of the opposite phase -> relock with the new phase_o.
- Reset mid-CONFIRM and mid-RUN: reset_n_i=0 for one cycle -> all outputs 0 next cycle, state IDLE, even with train_en_i=1 held.
